// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command front end for the 16-bit combinational ALU
// Holds an 8x16 register file, drives ALU operands, waits a settle window, captures and returns results.
module alu_cmd_sequencer #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_load,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_ra,
  input  logic [2:0]  cmd_rb,
  input  logic [15:0] cmd_imm,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_q,
  input  logic        alu_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_cout,
  output logic        res_err,
  output logic [2:0]  res_rd
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] rf [8];
  logic        op_legal;

  assign op_legal = (cmd_op == OP_AND) || (cmd_op == OP_OR) || (cmd_op == OP_ADD) ||
                    (cmd_op == OP_SUB) || (cmd_op == OP_SLT);

  // res_rd doubles as the writeback index while the ALU settles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      cnt       <= 4'd0;
      alu_a     <= 16'd0;
      alu_b     <= 16'd0;
      alu_op    <= 3'b000;
      res_data  <= 16'd0;
      res_cout  <= 1'b0;
      res_err   <= 1'b0;
      res_rd    <= 3'd0;
      for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            res_rd    <= cmd_rd;
            if (cmd_load) begin
              rf[cmd_rd] <= cmd_imm;
              res_data   <= cmd_imm;
              res_cout   <= 1'b0;
              res_err    <= 1'b0;
              res_valid  <= 1'b1;
              state      <= RESP;
            end else if (op_legal) begin
              alu_a  <= rf[cmd_ra];
              alu_b  <= rf[cmd_rb];
              alu_op <= cmd_op;
              cnt    <= 4'(SETTLE - 1);
              state  <= ISSUE;
            end else begin
              res_data  <= 16'd0;
              res_cout  <= 1'b0;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        ISSUE: begin
          if (cnt == 4'd0) begin
            rf[res_rd] <= alu_q;
            res_data   <= alu_q;
            res_cout   <= ((alu_op == OP_ADD) || (alu_op == OP_SUB)) ? alu_cout : 1'b0;
            res_err    <= 1'b0;
            res_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed and random checks of alu_cmd_sequencer against a reference model
module tb_alu_cmd_sequencer;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_load;
  logic [2:0]  cmd_op, cmd_rd, cmd_ra, cmd_rb;
  logic [15:0] cmd_imm;
  logic [15:0] alu_a, alu_b, alu_q;
  logic [2:0]  alu_op;
  logic        alu_cout;
  logic        res_valid, res_ready, res_cout, res_err;
  logic [15:0] res_data;
  logic [2:0]  res_rd;

  int checks = 0;
  int failures = 0;

  logic [15:0] mrf [8];
  logic [15:0] m_a, m_b;
  logic [2:0]  m_op;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_q(alu_q), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_err(res_err), .res_rd(res_rd)
  );

  // Stand-in ripple ALU: the adder carry is always driven, even for logic ops
  logic [16:0] alu_s;
  logic        alu_ov;
  always_comb begin
    alu_s    = {1'b0, alu_a} + {1'b0, (alu_op[2] ? ~alu_b : alu_b)} + {16'd0, alu_op[2]};
    alu_ov   = (alu_a[15] ^ alu_b[15]) & (alu_s[15] ^ alu_a[15]);
    alu_cout = alu_s[16];
    case (alu_op[1:0])
      2'b00:   alu_q = alu_a & alu_b;
      2'b01:   alu_q = alu_a | alu_b;
      2'b10:   alu_q = alu_s[15:0];
      default: alu_q = {15'd0, alu_s[15] ^ alu_ov};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic ld, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] imm,
                       output logic [15:0] d, output logic c, output logic e, output int lat);
    int unsigned a, b, s;
    a = mrf[ra];
    b = mrf[rb];
    c = 1'b0;
    e = 1'b0;
    lat = 1;
    if (ld) begin
      d = imm;
      mrf[rd] = imm;
    end else if (op == 3'd3 || op == 3'd4 || op == 3'd5) begin
      d = 16'd0;
      e = 1'b1;
    end else begin
      case (op)
        3'd0: d = 16'(a & b);
        3'd1: d = 16'(a | b);
        3'd2: begin s = a + b; d = 16'(s % 65536); c = (s > 65535); end
        3'd6: begin d = 16'((a + 65536 - b) % 65536); c = (a >= b); end
        default: d = ($signed(mrf[ra]) < $signed(mrf[rb])) ? 16'd1 : 16'd0;
      endcase
      m_a = mrf[ra];
      m_b = mrf[rb];
      m_op = op;
      lat = 1 + SETTLE;
      mrf[rd] = d;
    end
  endtask

  task automatic cmd_resp(input logic ld, input logic [2:0] op, input logic [2:0] rd,
                          input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] imm,
                          input logic pre, output int w);
    logic [15:0] ed;
    logic ec, ee;
    int el, lat;
    model(ld, op, rd, ra, rb, imm, ed, ec, ee, el);
    cmd_load = ld; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    cmd_valid = 1'b1;
    res_ready = pre;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    chk("accept_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!res_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("latency", lat, el);
    chk("res_data", res_data, ed);
    chk("res_cout", res_cout, ec);
    chk("res_err", res_err, ee);
    chk("res_rd", res_rd, rd);
    chk("cmd_ready_resp", cmd_ready, 0);
    chk("alu_op", alu_op, m_op);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
  endtask

  task automatic hs(input int hold);
    logic [15:0] d0;
    logic [2:0] r0;
    logic c0, e0;
    d0 = res_data; r0 = res_rd; c0 = res_cout; e0 = res_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, d0);
      chk("hold_rd", res_rd, r0);
      chk("hold_flags", {res_cout, res_err}, {c0, e0});
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk("hs_valid_low", res_valid, 0);
    chk("hs_cmd_ready", cmd_ready, 1);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 8; i++) mrf[i] = 16'd0;
    m_a = 16'd0; m_b = 16'd0; m_op = 3'd0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res"}, {res_data, res_cout, res_err, res_rd}, 0);
    chk({tag, "_alu"}, {alu_a, alu_b, alu_op}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    cmd_valid = 0; cmd_load = 0; cmd_op = 0; cmd_rd = 0; cmd_ra = 0; cmd_rb = 0; cmd_imm = 0;
    res_ready = 0;
    reset_model();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outs("post_reset");

    // add / dependent add
    cmd_resp(1, 3'd0, 3'd1, 3'd0, 3'd0, 16'd2, 0, w); hs(0);
    cmd_resp(1, 3'd0, 3'd2, 3'd0, 3'd0, 16'd3, 0, w); hs(0);
    cmd_resp(0, 3'b010, 3'd3, 3'd1, 3'd2, 16'd0, 0, w); hs(0);
    cmd_resp(0, 3'b010, 3'd4, 3'd3, 3'd3, 16'd0, 1, w); hs(0);
    // sub with carry, and with masked carry
    cmd_resp(1, 3'd0, 3'd1, 3'd0, 3'd0, 16'd60000, 0, w); hs(0);
    cmd_resp(1, 3'd0, 3'd2, 3'd0, 3'd0, 16'd50000, 0, w); hs(0);
    cmd_resp(0, 3'b110, 3'd5, 3'd1, 3'd2, 16'd0, 0, w); hs(0);
    cmd_resp(1, 3'd0, 3'd1, 3'd0, 3'd0, 16'hE3DA, 0, w); hs(0);
    cmd_resp(1, 3'd0, 3'd2, 3'd0, 3'd0, 16'hE508, 0, w); hs(0);
    cmd_resp(0, 3'b000, 3'd6, 3'd1, 3'd2, 16'd0, 0, w); hs(1);
    // slt both ways, then read back rd via or
    cmd_resp(1, 3'd0, 3'd1, 3'd0, 3'd0, 16'd2, 0, w); hs(0);
    cmd_resp(1, 3'd0, 3'd2, 3'd0, 3'd0, 16'd3, 0, w); hs(0);
    cmd_resp(0, 3'b111, 3'd7, 3'd1, 3'd2, 16'd0, 0, w); hs(0);
    cmd_resp(0, 3'b001, 3'd0, 3'd7, 3'd7, 16'd0, 0, w); hs(0);
    cmd_resp(1, 3'd0, 3'd1, 3'd0, 3'd0, 16'd654, 0, w); hs(0);
    cmd_resp(1, 3'd0, 3'd2, 3'd0, 3'd0, 16'd111, 0, w); hs(0);
    cmd_resp(0, 3'b111, 3'd7, 3'd1, 3'd2, 16'd0, 0, w); hs(0);
    cmd_resp(0, 3'b001, 3'd0, 3'd7, 3'd7, 16'd0, 0, w); hs(0);
    // illegal op leaves r6 and alu_* untouched
    cmd_resp(1, 3'd0, 3'd6, 3'd0, 3'd0, 16'h1234, 0, w); hs(0);
    cmd_resp(0, 3'b011, 3'd6, 3'd1, 3'd2, 16'd0, 0, w); hs(0);
    cmd_resp(0, 3'b001, 3'd0, 3'd6, 3'd6, 16'd0, 0, w); hs(0);

    // backpressure with a pending command waiting behind it
    cmd_resp(0, 3'b010, 3'd3, 3'd1, 3'd2, 16'd0, 0, w);
    cmd_load = 1; cmd_op = 0; cmd_rd = 3'd7; cmd_ra = 0; cmd_rb = 0; cmd_imm = 16'hBEEF;
    cmd_valid = 1'b1;
    hs(5);
    cmd_resp(1, 3'd0, 3'd7, 3'd0, 3'd0, 16'hBEEF, 0, w);
    chk("pending_first_idle", w, 0);
    hs(0);

    // reset in the middle of ISSUE
    cmd_load = 0; cmd_op = 3'b010; cmd_rd = 3'd3; cmd_ra = 3'd1; cmd_rb = 3'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("issue_before_reset", {cmd_ready, res_valid}, 2'b00);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("mid_issue_reset");
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_resp_after_reset", res_valid, 0);
    end
    cmd_resp(1, 3'd0, 3'd1, 3'd0, 3'd0, 16'd5, 0, w); hs(0);
    cmd_resp(0, 3'b010, 3'd0, 3'd3, 3'd1, 16'd0, 0, w); hs(0);

    // random commands against the model
    for (int i = 0; i < 24; i++) begin
      logic ld, pre;
      logic [2:0] op, rd, ra, rb;
      logic [15:0] imm;
      int hold;
      ld   = ($urandom_range(0, 2) == 0);
      op   = 3'($urandom_range(0, 7));
      rd   = 3'($urandom_range(0, 7));
      ra   = 3'($urandom_range(0, 7));
      rb   = 3'($urandom_range(0, 7));
      imm  = 16'($urandom);
      pre  = 1'($urandom_range(0, 1));
      hold = pre ? 0 : $urandom_range(0, 2);
      cmd_resp(ld, op, rd, ra, rb, imm, pre, w);
      hs(hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Sequential command front end that sits directly upstream of the 16-bit combinational ALU. It accepts register-to-register ALU commands over a valid/ready handshake and holds an 8×16 register file. It drives the ALU operand and opcode inputs from registers, waits a fixed settle window for the ripple-carry path, then captures the ALU result, writes it back and presents it downstream over a second valid/ready handshake.

## Interface
- SETTLE, 2: cycles the ALU inputs are held before capture; legal 1..15.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_load  in  1  1 = load immediate into rd; 0 = ALU operation.
- cmd_op  in  3  ALU opcode: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- cmd_rd, cmd_ra, cmd_rb  in  3 each  destination and source register indices.
- cmd_imm  in  16  immediate for loads.
- alu_a, alu_b  out  16  registered operands to the ALU.
- alu_op  out  3  registered opcode to the ALU.
- alu_q  in  16  ALU result.
- alu_cout  in  1  ALU carry out.
- res_valid  out  1  result present.
- res_ready  in  1  downstream accepts result.
- res_data  out  16  result value.
- res_cout  out  1  carry for add/sub; 0 otherwise.
- res_err  out  1  illegal opcode flag.
- res_rd  out  3  destination index of this result.

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: cmd_ready=1. A command is accepted on a clk edge with cmd_valid&&cmd_ready.
- On an accepted ALU command with a legal op: latch rf[ra]→alu_a, rf[rb]→alu_b and op→alu_op; load the settle counter with SETTLE-1; go to ISSUE.
- On an accepted ALU command with an illegal op (011, 100, 101): do not change alu_*. Set res_err=1, res_data=0, res_cout=0 and res_rd=rd. Go to RESP. No writeback.
- On an accepted load: rf[rd]←imm. Set res_data=imm, res_err=0, res_cout=0 and res_rd=rd. Go to RESP.
- ISSUE: alu_a, alu_b and alu_op are held constant. The counter decrements each cycle. In the cycle where the counter is 0, the next edge captures alu_q into res_data and into rf[rd]. On that edge, res_cout is set to alu_cout for 010/110 and to 0 otherwise, res_err=0, and the state goes to RESP.
- RESP: res_valid=1. res_data, res_cout, res_err and res_rd are stable until res_valid&&res_ready is sampled on an edge; then the state returns to IDLE.
- alu_a, alu_b and alu_op keep their last values outside ISSUE. They change only on command acceptance.
- Register file: 8×16, all entries writable, no bypass needed. Writeback always completes before the next acceptance, so a dependent command reads the updated value.
- ra==rb and rd==ra/rb are all legal. Sources are read at acceptance, before writeback.
- Arithmetic is the ALU's. The sequencer does not modify alu_q. Width is 16 bits, wrap-around is as produced by the ALU, and slt yields 0 or 1 exactly as alu_q reports.

## Timing
- Reset (async assert, sync-safe deassert):
  - state is IDLE and cmd_ready=1.
  - res_valid=0, res_data=0, res_cout=0, res_err=0, res_rd=0.
  - alu_a=0, alu_b=0, alu_op=000.
  - all rf entries are 0.
- Reset during ISSUE or RESP aborts the command: no writeback, no response.
- ALU command latency is 1+SETTLE cycles from the accept edge to res_valid=1. With SETTLE=2, accept at edge N gives res_valid high after edge N+3 (alu_* valid after N+1, capture at N+3).
- Load and illegal-op latency: res_valid=1 after the accept edge + 1.
- Minimum issue interval is latency + 1 (the RESP handshake edge), when res_ready is held high.
- No command is accepted in ISSUE or RESP. cmd_valid may stay high while cmd_ready=0; the command is taken on the first IDLE edge.
- res_ready may be high before res_valid. The handshake completes on the first edge with both high.

## Test plan
- Load r1=2, r2=3, then add r3=r1+r2 (op 010) → res_data=5, res_cout=0, res_rd=3; res_valid asserts exactly 3 cycles after accept with SETTLE=2; a following add r4=r3+r3 → 10.
- Load r1=60000, r2=50000, then sub r5=r1−r2 (op 110) → res_data=10000, res_cout=1; and (op 000) of 0xE3DA,0xE508 → 0xE108, res_cout=0.
- slt r1=2,r2=3 → res_data=1; slt r1=654,r2=111 → res_data=0; rd contents match res_data.
- Op 011 with rd=6 holding 0x1234 → res_err=1, res_data=0, 1-cycle latency, r6 still 0x1234, alu_op unchanged.
- res_ready held low 5 cycles in RESP → res_valid, res_data and res_rd stable, cmd_ready=0 throughout, pending cmd_valid accepted on the IDLE edge after the handshake.
- Assert rst_n low mid-ISSUE of add to r3 → all outputs at reset values immediately (async), r3=0 after release, no response emitted.
